// File: rtl/parking_exit.sv
// Exit-side car park controller: vehicle table, fee calculation, payment
// collection and exit gate sequencing. The entry side registers vehicles
// through park_in/vn_in; the exit FSM looks them up, charges and releases.
module parking_exit #(
  parameter int N        = 4,
  parameter int TICK_DIV = 8,
  parameter int FEE_RATE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         park_in,
  input  logic [N-1:0] vn_in,
  input  logic         ex_sens,
  input  logic [N-1:0] vn,
  input  logic         pay_valid,
  input  logic [7:0]   pay_amt,
  input  logic         bk_clear,
  output logic         gate_open,
  output logic [7:0]   fee,
  output logic         fee_valid,
  output logic         err,
  output logic [N:0]   occupancy,
  output logic         full
);

  localparam int SLOTS = 2**N;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [N:0]    OCC_MAX   = (N+1)'(SLOTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_ERROR,
    S_PAY,
    S_OPEN
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]    presc;
  logic [7:0]       now;
  logic [SLOTS-1:0] present;
  logic [7:0]       stamp [SLOTS];
  logic [N-1:0]     v;
  logic [7:0]       paid;
  logic             reg_ok;
  logic             rel_slot;

  // Fee from elapsed time units: scaled by the rate, capped at 255, never 0.
  function automatic logic [7:0] calc_fee(input logic [7:0] elapsed);
    logic [31:0] prod;
    prod = 32'(elapsed) * 32'(FEE_RATE);
    if (prod > 32'd255)
      return 8'hFF;
    else if (prod == 32'd0)
      return 8'd1;
    else
      return prod[7:0];
  endfunction

  // Saturating 8-bit accumulate for the running payment total.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // A registration is accepted only for an absent vehicle while not full;
  // full reflects the value before this cycle, so a same-cycle release does
  // not make room.
  assign reg_ok   = park_in && !present[vn_in] && !full;
  // The slot is freed on the very edge that moves PAY into OPEN.
  assign rel_slot = (state == S_PAY) && (paid >= fee);
  assign full     = (occupancy == OCC_MAX);

  // Time base: prescaler wraps every TICK_DIV cycles and advances now.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      now   <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      now   <= now + 8'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Occupancy table: registration sets, exit release clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      present   <= '0;
      occupancy <= '0;
    end else begin
      if (rel_slot) present[v]     <= 1'b0;
      if (reg_ok)   present[vn_in] <= 1'b1;
      occupancy <= occupancy + (N+1)'(reg_ok) - (N+1)'(rel_slot);
    end
  end

  // Entry timestamps; only meaningful where present is set.
  always_ff @(posedge clk) begin
    if (reg_ok) stamp[vn_in] <= now;
  end

  // Latch the departing vehicle and accumulate its payment.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && ex_sens) v <= vn;
    if (state == S_LOOKUP)
      paid <= 8'd0;
    else if (state == S_PAY && pay_valid)
      paid <= sat_add(paid, pay_amt);
  end

  // Fee is captured on the way into PAY and held until the next lookup.
  always_ff @(posedge clk) begin
    if (rst)
      fee <= 8'd0;
    else if (state == S_LOOKUP && present[v])
      fee <= calc_fee(now - stamp[v]);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ex_sens) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = present[v] ? S_PAY : S_ERROR;
      S_ERROR:  if (!ex_sens) state_nxt = S_IDLE;
      S_PAY: begin
        if (paid >= fee)   state_nxt = S_OPEN;
        else if (!ex_sens) state_nxt = S_IDLE;
      end
      S_OPEN:   if (bk_clear) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    gate_open = (state == S_OPEN);
    fee_valid = (state == S_PAY);
    err       = (state == S_ERROR);
  end

endmodule
